digit_serial_adder: RTL



---
 rtl/digit_serial_adder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor with accumulator: one DATA_W-bit operation is
// folded over N = DATA_W/DIGIT_W cycles through a DIGIT_W-wide carry chain.
module digit_serial_adder #(
  parameter int DATA_W  = 16,
  parameter int DIGIT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              sub_in,
  input  logic              acc_mode,
  input  logic              clr_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum_out,
  output logic              carry_out,
  output logic              overflow_out
);

  localparam int N     = DATA_W / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   sum_out_q, sum_out_d;
  logic                carry_out_q, carry_out_d;
  logic                ovf_q, ovf_d;

  logic [DIGIT_W-1:0]  a_dig;
  logic [DIGIT_W-1:0]  b_dig;
  logic [DIGIT_W:0]    dig_sum;
  logic                last_dig;
  logic [DATA_W-1:0]   b_src;

  // Select the active digit of each operand with a compare-per-digit mux so the
  // counter never needs to be widened into a bit-index expression.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_dig = a_q[k*DIGIT_W +: DIGIT_W];
        b_dig = b_q[k*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_W{1'b0}}, carry_q};
  assign last_dig = (cnt_q == CNT_W'(N - 1));

  // A clear coincident with an accumulate-mode accept feeds zero as operand B.
  assign b_src = acc_mode ? (clr_acc ? '0 : acc_q) : b_in;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    res_d       = res_q;
    acc_d       = acc_q;
    sum_out_d   = sum_out_q;
    carry_out_d = carry_out_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_src ^ {DATA_W{sub_in}};
          carry_d = sub_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            res_d[k*DIGIT_W +: DIGIT_W] = dig_sum[DIGIT_W-1:0];
          end
        end
        carry_d = dig_sum[DIGIT_W];
        if (last_dig) begin
          cnt_d       = '0;
          state_d     = DONE;
          sum_out_d   = res_d;
          carry_out_d = dig_sum[DIGIT_W];
          ovf_d       = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                        (res_d[DATA_W-1] != a_q[DATA_W-1]);
          acc_d       = res_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Clear has priority over the completion write-back.
    if (clr_acc) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      res_q       <= '0;
      acc_q       <= '0;
      sum_out_q   <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      sum_out_q   <= sum_out_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign sum_out      = sum_out_q;
  assign carry_out    = carry_out_q;
  assign overflow_out = ovf_q;

endmodule
